channel_packetizer: RTL and testbench
=====================================

# channel_packetizer

Downstream of the memory-to-stream reader: consumes the N per-channel word streams and merges them onto one AXI-Stream master. Each channel's words are cut into packets of a programmed byte length, with tlast, tkeep and tdest (channel index) attached. Channels are arbitrated round-robin at packet boundaries. The block runs a start/core_ready command cycle that mirrors the reader's.

## Interface
Parameters:
- DWIDTH, 512: data width in bits; BYTES = DWIDTH/8, power of two.
- N_CHANNELS, 16: channel count, 1..16.
- LEN_WIDTH, 16: width of the packet byte length.
- CNT_WIDTH, 32: width of the packet count.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- pkt_len[N_CHANNELS]  in  LEN_WIDTH  packet byte length per channel; sampled on accepted start.
- pkt_count[N_CHANNELS]  in  CNT_WIDTH  packets to emit per channel; sampled on accepted start.
- start  in  1  begin a run; accepted only when core_ready=1.
- core_ready  out  1  idle / run complete.
- channel_tdata[N_CHANNELS]  in  DWIDTH  word from reader channel i.
- channel_tvalid  in  N_CHANNELS  per-channel valid.
- channel_tready  out  N_CHANNELS  per-channel ready.
- m_axis_tdata  out  DWIDTH  merged output data.
- m_axis_tkeep  out  BYTES  byte enables.
- m_axis_tlast  out  1  last beat of packet.
- m_axis_tdest  out  4  source channel index.
- m_axis_tvalid  out  1  output valid.
- m_axis_tready  in  1  output ready.

## Operation
- Accepted start (start && core_ready):
  - Each channel i latches pkt_len[i] and remaining = pkt_count[i].
  - A channel with pkt_len=0 or pkt_count=0 is inactive (remaining forced to 0).
- Beats per packet: B = (len + BYTES-1) >> log2(BYTES). This is LEN_WIDTH-log2(BYTES)+1 bits and is computed at latch time.
- One input word maps to one output beat. Every packet starts on a fresh word; unused bytes of a packet's last word are discarded, not carried over.
- tkeep:
  - All ones on non-last beats.
  - On the last beat: all ones if len mod BYTES = 0, else the low (len mod BYTES) bits set.
- tdest = granted channel index. tlast = 1 on beat B.
- Arbiter:
  - States: IDLE and GRANT.
  - IDLE: the eligible set is {active channels with channel_tvalid=1}. Pick the first eligible index after last_grant, searching cyclically. Register the grant, reset the beat counter to 0, go to GRANT.
  - GRANT: channel_tready[g] = load, where load = !m_axis_tvalid || m_axis_tready. All other channel_tready bits are 0; in IDLE all are 0.
  - Each channel handshake increments the beat counter.
  - On the handshake of beat B: decrement remaining[g], set last_grant=g, return to IDLE.
- Output register: on load, capture data/keep/last/dest and set tvalid=1 when a channel handshake occurs; otherwise tvalid falls if m_axis_tready.
- core_ready:
  - Falls the cycle after an accepted start.
  - Rises when all remaining=0, the arbiter is in IDLE and m_axis_tvalid=0 (last beat accepted downstream).
  - A run with every channel inactive completes with core_ready back at 1 two cycles after start.
- start while core_ready=0 is ignored; latched values are unchanged.

## Timing
- Reset values: core_ready=1, m_axis_tvalid=0, m_axis_tlast=0, m_axis_tkeep=0, m_axis_tdest=0, m_axis_tdata=0, channel_tready=0, all remaining=0, arbiter IDLE, last_grant=N_CHANNELS-1 (so channel 0 wins first).
- Reset mid-run: the output beat and partial packet are dropped and all channels go inactive. Upstream words stay in the reader FIFOs; flushing them is the system's job.
- Arbitration costs 1 cycle: a grant is registered the cycle after eligibility is seen, and channel_tready asserts that same cycle.
- Latency: channel handshake to m_axis_tvalid is 1 cycle.
- Throughput:
  - 1 beat/cycle within a packet when m_axis_tready=1.
  - One idle cycle between consecutive packets.
  - So B/(B+1) sustained.
- AXIS rules:
  - tdata/tkeep/tlast/tdest are stable while tvalid && !tready.
  - tvalid never drops without a handshake.
  - channel_tready does not depend combinationally on channel_tvalid.
- A grant is held for the whole packet even if the channel stalls (tvalid=0); no preemption.
- Remaining-count decrement and an accepted start cannot coincide, because start is accepted only when idle.

## Test plan
- DWIDTH=512, ch0 len=100, count=2, others 0:
  - Expect 4 beats, tdest=0, tlast on beats 2 and 4.
  - Last-beat tkeep = 0x0000000FFFFFFFFF (36 bytes); bytes 36..63 of the input word are dropped.
  - core_ready returns to 1 after the final accept.
- ch2 len=128, count=3:
  - Expect 6 beats, tkeep all ones on every beat, tlast on beats 2, 4 and 6.
- ch1 and ch3 len=64, count=3, both always valid:
  - Expect single-beat packets with tdest sequence 1,3,1,3,1,3 and one idle cycle between packets.
- Check B = 2 for ch0 len=65; while m_axis_tready=0, confirm all output fields stay stable.
- ch0 len=256, count=4, ch5 len=64, count=1, m_axis_tready toggled pseudo-randomly:
  - Output data matches the input words in order, with no duplication or loss.
  - A second start mid-run is ignored.
- Assert rst on beat 2 of a 4-beat packet:
  - Next cycle tvalid=0, channel_tready=0, core_ready=1.
  - A fresh start then runs normally.

Source files
------------

// File: rtl/channel_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : channel_packetizer
// Purpose  : Merges N per-channel word streams onto one AXI-Stream master,
//            cutting each channel into fixed-length packets, round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module channel_packetizer #(
   parameter int DWIDTH     = 512,
   parameter int N_CHANNELS = 16,
   parameter int LEN_WIDTH  = 16,
   parameter int CNT_WIDTH  = 32
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [LEN_WIDTH-1:0]    pkt_len [N_CHANNELS],
   input  logic [CNT_WIDTH-1:0]    pkt_count [N_CHANNELS],
   input  logic                    start,
   output logic                    core_ready,
   input  logic [DWIDTH-1:0]       channel_tdata [N_CHANNELS],
   input  logic [N_CHANNELS-1:0]   channel_tvalid,
   output logic [N_CHANNELS-1:0]   channel_tready,
   output logic [DWIDTH-1:0]       m_axis_tdata,
   output logic [DWIDTH/8-1:0]     m_axis_tkeep,
   output logic                    m_axis_tlast,
   output logic [3:0]              m_axis_tdest,
   output logic                    m_axis_tvalid,
   input  logic                    m_axis_tready
);

   localparam int c_BYTES = DWIDTH / 8;
   localparam int c_LOG   = $clog2(c_BYTES);
   localparam int c_BW    = LEN_WIDTH - c_LOG + 1;
   localparam int c_GW    = (N_CHANNELS > 1) ? $clog2(N_CHANNELS) : 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } state_t;

   state_t                r_state, w_state_nxt;
   logic [c_GW-1:0]       r_grant, r_last_grant, w_pick, w_idx;
   logic                  w_found;
   logic [c_BW-1:0]       r_beat;
   logic [c_BW-1:0]       r_beats [N_CHANNELS];
   logic [c_LOG-1:0]      r_tail [N_CHANNELS];
   logic [CNT_WIDTH-1:0]  r_remaining [N_CHANNELS];
   logic [N_CHANNELS-1:0] w_active, w_elig;
   logic                  w_load, w_hs, w_last_beat, w_start_acc, w_all_idle;
   logic [c_BYTES-1:0]    w_keep_last;
   logic                  r_core_ready, r_tvalid, r_tlast;
   logic [DWIDTH-1:0]     r_tdata;
   logic [c_BYTES-1:0]    r_tkeep;
   logic [3:0]            r_tdest;

   assign w_start_acc = start && r_core_ready;
   assign w_load      = !r_tvalid || m_axis_tready;

   // Per-channel configuration latched on start; beats = ceil(len / BYTES).
   generate
      for (genvar i = 0; i < N_CHANNELS; i++) begin : g_chan
         assign w_active[i] = (r_remaining[i] != '0);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_remaining[i] <= '0;
               r_beats[i]     <= '0;
               r_tail[i]      <= '0;
            end else if (w_start_acc) begin
               r_beats[i]     <= {1'b0, pkt_len[i][LEN_WIDTH-1:c_LOG]}
                                 + c_BW'(pkt_len[i][c_LOG-1:0] != '0);
               r_tail[i]      <= pkt_len[i][c_LOG-1:0];
               r_remaining[i] <= (pkt_len[i] == '0) ? '0 : pkt_count[i];
            end else if (w_hs && w_last_beat && (r_grant == c_GW'(i))) begin
               r_remaining[i] <= r_remaining[i] - 1'b1;
            end
         end
      end
   endgenerate

   // Cyclic search starting just after the previous winner.
   always_comb begin
      w_elig  = w_active & channel_tvalid;
      w_pick  = r_last_grant;
      w_found = 1'b0;
      w_idx   = '0;
      for (int k = 1; k <= N_CHANNELS; k++) begin
         w_idx = c_GW'((int'(r_last_grant) + k) % N_CHANNELS);
         if (!w_found && w_elig[w_idx]) begin
            w_found = 1'b1;
            w_pick  = w_idx;
         end
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      channel_tready = '0;
      w_hs           = 1'b0;
      w_last_beat    = ((r_beat + 1'b1) == r_beats[r_grant]);
      case (r_state)
         ST_IDLE: begin
            if (w_found) w_state_nxt = ST_GRANT;
         end
         ST_GRANT: begin
            channel_tready[r_grant] = w_load;
            w_hs = w_load && channel_tvalid[r_grant];
            if (w_hs && w_last_beat) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= ST_IDLE;
         r_grant      <= '0;
         r_last_grant <= c_GW'(N_CHANNELS - 1);
         r_beat       <= '0;
      end else begin
         r_state <= w_state_nxt;
         if ((r_state == ST_IDLE) && w_found) begin
            r_grant <= w_pick;
            r_beat  <= '0;
         end else if (w_hs) begin
            r_beat <= r_beat + 1'b1;
            if (w_last_beat) r_last_grant <= r_grant;
         end
      end
   end

   // A zero tail means the packet ends on a word boundary: keep every byte.
   assign w_keep_last = (r_tail[r_grant] == '0) ? '1
                        : ~({c_BYTES{1'b1}} << r_tail[r_grant]);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tvalid <= 1'b0;
         r_tdata  <= '0;
         r_tkeep  <= '0;
         r_tlast  <= 1'b0;
         r_tdest  <= '0;
      end else if (w_load) begin
         r_tvalid <= w_hs;
         if (w_hs) begin
            r_tdata <= channel_tdata[r_grant];
            r_tkeep <= w_last_beat ? w_keep_last : '1;
            r_tlast <= w_last_beat;
            r_tdest <= 4'(r_grant);
         end
      end
   end

   assign w_all_idle = (w_active == '0) && (r_state == ST_IDLE) && !r_tvalid;

   always_ff @(posedge clk) begin
      if (rst)              r_core_ready <= 1'b1;
      else if (w_start_acc) r_core_ready <= 1'b0;
      else if (w_all_idle)  r_core_ready <= 1'b1;
   end

   assign core_ready    = r_core_ready;
   assign m_axis_tdata  = r_tdata;
   assign m_axis_tkeep  = r_tkeep;
   assign m_axis_tlast  = r_tlast;
   assign m_axis_tdest  = r_tdest;
   assign m_axis_tvalid = r_tvalid;

endmodule
`default_nettype wire

// File: tb/tb_channel_packetizer.sv
`default_nettype none
// ============================================================================
// Module   : tb_channel_packetizer
// Purpose  : Randomized bench for channel_packetizer with a packet-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_channel_packetizer;

   localparam int DW = 512;
   localparam int NC = 16;
   localparam int LW = 16;
   localparam int CW = 32;
   localparam int BY = DW / 8;

   logic           clk = 1'b0;
   logic           rst;
   logic [LW-1:0]  pkt_len [NC];
   logic [CW-1:0]  pkt_count [NC];
   logic           start;
   logic           core_ready;
   logic [DW-1:0]  channel_tdata [NC];
   logic [NC-1:0]  channel_tvalid;
   logic [NC-1:0]  channel_tready;
   logic [DW-1:0]  m_axis_tdata;
   logic [BY-1:0]  m_axis_tkeep;
   logic           m_axis_tlast;
   logic [3:0]     m_axis_tdest;
   logic           m_axis_tvalid;
   logic           m_axis_tready;

   channel_packetizer #(
      .DWIDTH(DW), .N_CHANNELS(NC), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
   ) dut (
      .clk(clk), .rst(rst), .pkt_len(pkt_len), .pkt_count(pkt_count),
      .start(start), .core_ready(core_ready),
      .channel_tdata(channel_tdata), .channel_tvalid(channel_tvalid),
      .channel_tready(channel_tready),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tlast(m_axis_tlast), .m_axis_tdest(m_axis_tdest),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model / bookkeeping state
   int cfg_len [NC];
   int cfg_cnt [NC];
   int src_idx [NC];
   int base [NC];
   int mlen [NC];
   int mbeats [NC];
   int exp_total [NC];
   int got_cnt [NC];
   int total_exp, total_got;
   int model_last_g = NC - 1;
   int order_q [$];
   int order_pos;
   bit check_order;
   int cyc = 0;
   int last_hs_cycle;
   int last_seen_ch;
   bit in_pkt;
   int cur_ch;
   bit all_valid;
   int rdy_mode;
   bit mon_en;
   int last_budget;
   bit prev_hold;
   logic [DW-1:0]   prev_data;
   logic [BY+4:0]   prev_ctl;

   task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [DW-1:0] word(input int ch, input int k);
      logic [DW-1:0] w;
      for (int s = 0; s < DW / 32; s++)
         w[s*32 +: 32] = {8'(ch), 16'(k), 8'(s)} ^ (32'(s) * 32'h9E3779B9);
      return w;
   endfunction

   function automatic logic [BY-1:0] keep_exp(input int len, input bit last);
      logic [BY-1:0] k;
      int m;
      m = len % BY;
      for (int b = 0; b < BY; b++) k[b] = !last || (m == 0) || (b < m);
      return k;
   endfunction

   function automatic logic [DW-1:0] byte_mask(input logic [BY-1:0] k);
      logic [DW-1:0] m;
      for (int b = 0; b < BY; b++) m[b*8 +: 8] = {8{k[b]}};
      return m;
   endfunction

   task automatic drive_inputs(input logic [NC-1:0] hs);
      for (int i = 0; i < NC; i++) begin
         if (!(channel_tvalid[i] && !hs[i]))
            channel_tvalid[i] = all_valid ? 1'b1 : ($urandom_range(0, 2) != 0);
         channel_tdata[i] = word(i, src_idx[i]);
      end
      m_axis_tready = (rdy_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
   endtask

   task automatic check_beat(input int ch, input logic [DW-1:0] d,
                             input logic [BY-1:0] k, input logic l);
      int j, p;
      bit last;
      logic [BY-1:0] ek;
      chk("beat_expected", DW'(got_cnt[ch] < exp_total[ch]), DW'(1));
      if (got_cnt[ch] < exp_total[ch]) begin
         j    = got_cnt[ch];
         p    = j % mbeats[ch];
         last = (p == mbeats[ch] - 1);
         ek   = keep_exp(mlen[ch], last);
         chk("tkeep", DW'(k), DW'(ek));
         chk("tlast", DW'(l), DW'(last));
         chk("tdata", d & byte_mask(ek), word(ch, base[ch] + j) & byte_mask(ek));
         if (in_pkt) chk("pkt_interleave", DW'(ch), DW'(cur_ch));
         if (check_order) begin
            if (p == 0) begin
               if (order_pos < order_q.size())
                  chk("rr_order", DW'(ch), DW'(order_q[order_pos]));
               order_pos++;
               if (total_got > 0) chk("pkt_gap", DW'(cyc - last_hs_cycle), DW'(2));
            end else begin
               chk("beat_gap", DW'(cyc - last_hs_cycle), DW'(1));
            end
         end
         in_pkt = !last;
         cur_ch = ch;
         got_cnt[ch]++;
      end
      total_got++;
      last_hs_cycle = cyc;
      last_seen_ch  = ch;
   endtask

   // Called just after a falling edge with inputs already driven.
   task automatic cycle();
      logic [NC-1:0] hs_ch;
      logic          hs_out;
      logic [DW-1:0] d;
      logic [BY-1:0] k;
      logic          l;
      logic [3:0]    t;
      #1;
      if (mon_en) begin
         if (prev_hold) begin
            chk("hold_valid", DW'(m_axis_tvalid), DW'(1));
            chk("hold_data", m_axis_tdata, prev_data);
            chk("hold_ctl", DW'({m_axis_tkeep, m_axis_tlast, m_axis_tdest}), DW'(prev_ctl));
         end
         chk("tready_onehot", DW'($onehot0(channel_tready)), DW'(1));
      end
      prev_hold = m_axis_tvalid && !m_axis_tready;
      prev_data = m_axis_tdata;
      prev_ctl  = {m_axis_tkeep, m_axis_tlast, m_axis_tdest};
      hs_ch  = channel_tvalid & channel_tready;
      hs_out = m_axis_tvalid && m_axis_tready;
      d = m_axis_tdata; k = m_axis_tkeep; l = m_axis_tlast; t = m_axis_tdest;
      @(posedge clk);
      cyc++;
      @(negedge clk);
      for (int i = 0; i < NC; i++) if (hs_ch[i]) src_idx[i]++;
      if (mon_en && hs_out) check_beat(int'(t), d, k, l);
      drive_inputs(hs_ch);
   endtask

   task automatic do_reset();
      mon_en = 1'b0;
      rst = 1'b1;
      cycle();
      cycle();
      rst = 1'b0;
      mon_en = 1'b1;
      prev_hold = 1'b0;
      in_pkt = 1'b0;
      model_last_g = NC - 1;
   endtask

   task automatic clear_cfg();
      for (int i = 0; i < NC; i++) begin
         cfg_len[i] = 0;
         cfg_cnt[i] = 0;
      end
   endtask

   task automatic begin_run(input bit allv, input int rmode);
      int rem [NC];
      int g;
      all_valid = allv;
      rdy_mode  = rmode;
      total_exp = 0;
      total_got = 0;
      in_pkt    = 1'b0;
      for (int i = 0; i < NC; i++) begin
         pkt_len[i]   = LW'(cfg_len[i]);
         pkt_count[i] = CW'(cfg_cnt[i]);
         mlen[i]      = cfg_len[i];
         mbeats[i]    = (cfg_len[i] + BY - 1) / BY;
         rem[i]       = (cfg_len[i] != 0) ? cfg_cnt[i] : 0;
         exp_total[i] = rem[i] * mbeats[i];
         got_cnt[i]   = 0;
         base[i]      = src_idx[i];
         total_exp   += exp_total[i];
      end
      order_q.delete();
      order_pos   = 0;
      check_order = allv && (rmode == 0);
      g = model_last_g;
      for (int n = 0; n < 100000; n++) begin
         bit f;
         f = 1'b0;
         for (int k = 1; k <= NC; k++) begin
            int c;
            c = (g + k) % NC;
            if (!f && rem[c] > 0) begin
               f = 1'b1;
               order_q.push_back(c);
               rem[c]--;
               g = c;
            end
         end
         if (!f) break;
      end
      if (check_order) model_last_g = g;
      chk("ready_before_start", DW'(core_ready), DW'(1));
      start = 1'b1;
      cycle();
      start = 1'b0;
      for (int i = 0; i < NC; i++) begin
         pkt_len[i]   = LW'($urandom_range(1, 500));
         pkt_count[i] = CW'($urandom_range(1, 9));
      end
      chk("ready_after_start", DW'(core_ready), DW'(0));
   endtask

   task automatic run(input bit allv, input int rmode, input int restart_at);
      int budget;
      begin_run(allv, rmode);
      budget = 0;
      while (!(core_ready && total_got >= total_exp) && budget < 3000) begin
         if (budget == restart_at) start = 1'b1;
         cycle();
         start = 1'b0;
         budget++;
         if (core_ready) chk("ready_vs_beats", DW'(total_got), DW'(total_exp));
      end
      last_budget = budget;
      chk("beats_total", DW'(total_got), DW'(total_exp));
      chk("ready_end", DW'(core_ready), DW'(1));
      chk("tvalid_end", DW'(m_axis_tvalid), DW'(0));
      if (!check_order && total_got > 0) model_last_g = last_seen_ch;
   endtask

   initial begin
      int w;
      rst = 1'b1;
      start = 1'b0;
      all_valid = 1'b0;
      rdy_mode = 0;
      mon_en = 1'b0;
      prev_hold = 1'b0;
      channel_tvalid = '0;
      for (int i = 0; i < NC; i++) begin
         src_idx[i] = 0;
         pkt_len[i] = '0;
         pkt_count[i] = '0;
      end
      clear_cfg();
      @(negedge clk);
      drive_inputs('0);
      do_reset();

      chk("rst_core_ready", DW'(core_ready), DW'(1));
      chk("rst_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("rst_tlast", DW'(m_axis_tlast), DW'(0));
      chk("rst_tkeep", DW'(m_axis_tkeep), DW'(0));
      chk("rst_tdest", DW'(m_axis_tdest), DW'(0));
      chk("rst_tdata", m_axis_tdata, '0);
      chk("rst_ch_tready", DW'(channel_tready), DW'(0));

      clear_cfg(); cfg_len[0] = 100; cfg_cnt[0] = 2;
      run(1'b1, 0, -1);

      clear_cfg(); cfg_len[2] = 128; cfg_cnt[2] = 3;
      run(1'b1, 0, -1);

      do_reset();
      clear_cfg(); cfg_len[1] = 64; cfg_cnt[1] = 3; cfg_len[3] = 64; cfg_cnt[3] = 3;
      run(1'b1, 0, -1);

      clear_cfg(); cfg_len[0] = 65; cfg_cnt[0] = 2;
      run(1'b0, 1, -1);

      clear_cfg(); cfg_len[0] = 256; cfg_cnt[0] = 4; cfg_len[5] = 64; cfg_cnt[5] = 1;
      run(1'b0, 1, 5);

      clear_cfg(); cfg_len[0] = 0; cfg_cnt[0] = 5; cfg_len[1] = 10; cfg_cnt[1] = 0;
      run(1'b1, 0, -1);
      chk("idle_run_len", DW'(last_budget), DW'(1));

      // Reset while beat 2 of a 4-beat packet is on the output.
      do_reset();
      clear_cfg(); cfg_len[0] = 256; cfg_cnt[0] = 1;
      begin_run(1'b1, 0);
      w = 0;
      while (total_got < 1 && w < 50) begin
         cycle();
         w++;
      end
      chk("rst_reached_beat2", DW'((total_got == 1) && m_axis_tvalid), DW'(1));
      rst = 1'b1;
      m_axis_tready = 1'b0;
      mon_en = 1'b0;
      cycle();
      rst = 1'b0;
      chk("midrst_tvalid", DW'(m_axis_tvalid), DW'(0));
      chk("midrst_ch_tready", DW'(channel_tready), DW'(0));
      chk("midrst_ready", DW'(core_ready), DW'(1));
      mon_en = 1'b1;
      prev_hold = 1'b0;
      in_pkt = 1'b0;
      model_last_g = NC - 1;
      run(1'b1, 0, -1);

      for (int r = 0; r < 6; r++) begin
         for (int i = 0; i < NC; i++) begin
            if ($urandom_range(0, 2) == 0) begin
               cfg_len[i] = $urandom_range(0, 300);
               cfg_cnt[i] = $urandom_range(0, 3);
            end else begin
               cfg_len[i] = 0;
               cfg_cnt[i] = 0;
            end
         end
         run(1'($urandom_range(0, 1)), $urandom_range(0, 1), (r % 2 == 1) ? 3 : -1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
